// File: rtl/pipeline_pkg.sv
// Shared pipeline widths, reset PC and the fetch FSM state type.
package pipeline_pkg;

    localparam int unsigned PC_W = 13;
    localparam int unsigned INSTR_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 13'h0000;

    typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_e;

    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect target, sequential +4 advance, or hold.
module fetch_pc_reg
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = pipeline_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            // Targets are word aligned; low bits are dropped rather than trapped.
            pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
        end else if (advance) begin
            pc_q <= pc_plus4(pc_q);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps at most one imem request in flight and holds one fetched entry.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = pipeline_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               aclr,
    input  logic               en,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instrF,
    output logic [PC_W-1:0]    pcF,
    output logic [PC_W-1:0]    pc4F,
    output logic               validF
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] req_pc_q;
    logic            buf_free;
    logic            issue;
    logic            consume;
    logic            load;

    assign buf_free = !validF || en;
    assign issue    = (state_q == FETCH) && buf_free && !redirect;
    assign consume  = validF && en;
    assign load     = (state_q == WAIT) && imem_rvalid && !redirect;

    // Nothing is requested while reset is held.
    assign imem_req  = issue && !aclr;
    assign imem_addr = pc;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .aclr       (aclr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .advance    (issue),
        .pc         (pc)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q  <= FETCH;
            req_pc_q <= '0;
            validF   <= 1'b0;
            instrF   <= '0;
            pcF      <= '0;
            pc4F     <= '0;
        end else begin
            if (issue) begin
                req_pc_q <= pc;
            end

            if (redirect) begin
                validF <= 1'b0;
                instrF <= '0;
                pcF    <= '0;
                pc4F   <= '0;
            end else if (load) begin
                validF <= 1'b1;
                instrF <= imem_rdata;
                pcF    <= req_pc_q;
                pc4F   <= pc_plus4(req_pc_q);
            end else if (consume) begin
                // pcF/pc4F keep their last value; only the instruction is zeroed.
                validF <= 1'b0;
                instrF <= '0;
            end

            unique case (state_q)
                FETCH: begin
                    if (issue) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end else if (redirect) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-scenario tasks with an expected-fetch scoreboard.
module tb_fetch_stage;
    import pipeline_pkg::*;

    logic               clk;
    logic               aclr;
    logic               en;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instrF;
    logic [PC_W-1:0]    pcF;
    logic [PC_W-1:0]    pc4F;
    logic               validF;

    logic               w_en;
    logic               w_redirect;
    logic [PC_W-1:0]    w_redirect_pc;
    logic               w_req;
    logic [PC_W-1:0]    w_addr;
    logic               w_rvalid;
    logic [INSTR_W-1:0] w_rdata;
    logic [INSTR_W-1:0] w_instrF;
    logic [PC_W-1:0]    w_pcF;
    logic [PC_W-1:0]    w_pc4F;
    logic               w_validF;

    fetch_stage u_dut (
        .clk        (clk),
        .aclr       (aclr),
        .en         (en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrF     (instrF),
        .pcF        (pcF),
        .pc4F       (pc4F),
        .validF     (validF)
    );

    fetch_stage #(
        .RESET_PC(13'h1FFC)
    ) u_wrap (
        .clk        (clk),
        .aclr       (aclr),
        .en         (w_en),
        .redirect   (w_redirect),
        .redirect_pc(w_redirect_pc),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_rvalid(w_rvalid),
        .imem_rdata (w_rdata),
        .instrF     (w_instrF),
        .pcF        (w_pcF),
        .pc4F       (w_pc4F),
        .validF     (w_validF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc4;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    // Inputs applied at the next falling edge.
    logic               nx_aclr = 1'b1;
    logic               nx_en = 1'b1;
    logic               nx_redirect = 1'b0;
    logic [PC_W-1:0]    nx_rpc = '0;
    logic               nx_wrv = 1'b0;
    logic [INSTR_W-1:0] nx_wrd = '0;

    // Memory model state.
    bit                 mem_auto = 1'b0;
    int                 mem_lat = 1;
    bit                 pend = 1'b0;
    logic [PC_W-1:0]    pend_addr = '0;
    int                 cnt = 0;
    bit                 force_rv = 1'b0;
    logic [INSTR_W-1:0] force_rd = '0;

    logic               req_seen;
    logic [PC_W-1:0]    req_addr_seen;

    function automatic logic [INSTR_W-1:0] pat(input logic [PC_W-1:0] a);
        return {19'h2A5C3, a};
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, score the main DUT.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        aclr        = nx_aclr;
        en          = nx_en;
        redirect    = nx_redirect;
        redirect_pc = nx_rpc;
        w_rvalid    = nx_wrv;
        w_rdata     = nx_wrd;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = force_rd;
        end else if (mem_auto && pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pat(pend_addr);
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
        #1;
        req_seen      = imem_req;
        req_addr_seen = imem_addr;
        if (validF !== 1'b1) begin
            checks++;
            if (instrF !== '0) begin
                failures++;
                $display("FAIL instr_zero_when_invalid: got %h want 0", instrF);
            end
        end
        if (validF === 1'b1 && en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fetch: got pcF=%h instrF=%h want no valid entry",
                         pcF, instrF);
            end else begin
                e = sb.pop_front();
                if (instrF !== e.instr || pcF !== e.pc || pc4F !== e.pc4) begin
                    failures++;
                    $display("FAIL fetch_entry: got %h/%h/%h want %h/%h/%h",
                             instrF, pcF, pc4F, e.instr, e.pc, e.pc4);
                end
            end
        end
        if (mem_auto && imem_req === 1'b1) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            cnt       = mem_lat - 1;
            e.instr   = pat(imem_addr);
            e.pc      = imem_addr;
            e.pc4     = imem_addr + 13'd4;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        nx_aclr = 1'b1;
        nx_en   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if ({validF, instrF, pcF, pc4F} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got v=%b i=%h pc=%h pc4=%h want all 0",
                         validF, instrF, pcF, pc4F);
            end
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("FAIL reset_req: got %b want 0", imem_req);
            end
        end
    endtask

    task automatic test_basic();
        int              rc;
        int              rcyc[3];
        logic [PC_W-1:0] raddr[3];
        rc       = 0;
        nx_aclr  = 1'b0;
        mem_auto = 1'b1;
        mem_lat  = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (req_seen === 1'b1 && rc < 3) begin
                rcyc[rc]  = i;
                raddr[rc] = req_addr_seen;
                rc++;
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (validF !== (i == 2)) begin
                    failures++;
                    $display("FAIL basic_valid_pulse: cycle %0d got %b want %b", i, validF, i == 2);
                end
            end
        end
        checks++;
        if (rc != 3) begin
            failures++;
            $display("FAIL basic_req_count: got %0d want 3", rc);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (raddr[k] !== PC_W'(4 * k) || rcyc[k] != 2 * k) begin
                    failures++;
                    $display("FAIL basic_req%0d: got addr %h at %0d want %h at %0d",
                             k, raddr[k], rcyc[k], PC_W'(4 * k), 2 * k);
                end
            end
        end
    endtask

    task automatic test_stall();
        nx_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (validF !== 1'b1 || pcF !== 13'h008 || pc4F !== 13'h00C || instrF !== pat(13'h008)) begin
                failures++;
                $display("FAIL stall_hold: got v=%b pc=%h pc4=%h i=%h want 1/008/00c/%h",
                         validF, pcF, pc4F, instrF, pat(13'h008));
            end
            checks++;
            if (req_seen !== 1'b0) begin
                failures++;
                $display("FAIL stall_req: got %b want 0", req_seen);
            end
        end
        nx_en = 1'b1;
        cycle();
        checks++;
        if (req_seen !== 1'b1 || req_addr_seen !== 13'h00C) begin
            failures++;
            $display("FAIL stall_resume: got req=%b addr=%h want 1/00c", req_seen, req_addr_seen);
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        found   = 1'b0;
        mem_lat = 3;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (req_seen === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || req_addr_seen !== 13'h010) begin
            failures++;
            $display("FAIL redir_wait_setup: got found=%b addr=%h want 1/010", found, req_addr_seen);
        end
        sb.delete();
        nx_redirect = 1'b1;
        nx_rpc      = 13'h040;
        cycle();
        nx_redirect = 1'b0;
        mem_lat     = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (validF !== 1'b0 || req_seen !== 1'b0) begin
                failures++;
                $display("FAIL redir_wait_drop: step %0d got v=%b req=%b want 0/0",
                         i, validF, req_seen);
            end
        end
        cycle();
        checks++;
        if (req_seen !== 1'b1 || req_addr_seen !== 13'h040 || validF !== 1'b0) begin
            failures++;
            $display("FAIL redir_wait_target: got req=%b addr=%h v=%b want 1/040/0",
                     req_seen, req_addr_seen, validF);
        end
        cycle();
        cycle();
        checks++;
        if (validF !== 1'b1 || pcF !== 13'h040) begin
            failures++;
            $display("FAIL redir_wait_pcF: got v=%b pc=%h want 1/040", validF, pcF);
        end
    endtask

    task automatic test_redirect_rvalid();
        for (int i = 0; i < 10 && req_seen !== 1'b1; i++) begin
            cycle();
        end
        sb.delete();
        nx_redirect = 1'b1;
        nx_rpc      = 13'h043;
        cycle();
        checks++;
        if (imem_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL redir_rv_setup: got rvalid=%b want 1", imem_rvalid);
        end
        nx_redirect = 1'b0;
        cycle();
        checks++;
        if (validF !== 1'b0 || req_seen !== 1'b1 || req_addr_seen !== 13'h040) begin
            failures++;
            $display("FAIL redir_rv_target: got v=%b req=%b addr=%h want 0/1/040",
                     validF, req_seen, req_addr_seen);
        end
        cycle();
        cycle();
        checks++;
        if (validF !== 1'b1 || pcF !== 13'h040 || instrF !== pat(13'h040)) begin
            failures++;
            $display("FAIL redir_rv_pcF: got v=%b pc=%h i=%h want 1/040/%h",
                     validF, pcF, instrF, pat(13'h040));
        end
    endtask

    task automatic test_aclr_wait();
        bit found;
        found   = 1'b0;
        mem_lat = 3;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (req_seen === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || pcF === '0) begin
            failures++;
            $display("FAIL aclr_setup: got found=%b pcF=%h want 1/nonzero", found, pcF);
        end
        mem_auto = 1'b0;
        pend     = 1'b0;
        sb.delete();
        nx_aclr  = 1'b1;
        cycle();
        checks++;
        if ({validF, instrF, pcF, pc4F, imem_req} !== '0) begin
            failures++;
            $display("FAIL aclr_async: got v=%b i=%h pc=%h pc4=%h req=%b want all 0",
                     validF, instrF, pcF, pc4F, imem_req);
        end
        force_rv = 1'b1;
        force_rd = 32'hDEAD_0001;
        cycle();
        checks++;
        if ({validF, instrF, imem_req} !== '0) begin
            failures++;
            $display("FAIL aclr_held: got v=%b i=%h req=%b want 0", validF, instrF, imem_req);
        end
        nx_aclr  = 1'b0;
        force_rd = 32'hBEEF_0002;
        mem_auto = 1'b1;
        mem_lat  = 1;
        cycle();
        force_rv = 1'b0;
        checks++;
        if (req_seen !== 1'b1 || req_addr_seen !== 13'h000 || validF !== 1'b0) begin
            failures++;
            $display("FAIL aclr_first_req: got req=%b addr=%h v=%b want 1/000/0",
                     req_seen, req_addr_seen, validF);
        end
        cycle();
        cycle();
        checks++;
        if (validF !== 1'b1 || instrF !== pat(13'h000) || pcF !== 13'h000) begin
            failures++;
            $display("FAIL aclr_first_fetch: got v=%b i=%h pc=%h want 1/%h/000",
                     validF, instrF, pcF, pat(13'h000));
        end
    endtask

    task automatic test_wrap();
        nx_aclr  = 1'b1;
        mem_auto = 1'b0;
        pend     = 1'b0;
        cycle();
        sb.delete();
        nx_aclr = 1'b0;
        cycle();
        checks++;
        if (w_req !== 1'b1 || w_addr !== 13'h1FFC) begin
            failures++;
            $display("FAIL wrap_first_req: got req=%b addr=%h want 1/1ffc", w_req, w_addr);
        end
        nx_wrv = 1'b1;
        nx_wrd = pat(13'h1FFC);
        cycle();
        nx_wrv = 1'b0;
        nx_wrd = '0;
        cycle();
        checks++;
        if (w_validF !== 1'b1 || w_pcF !== 13'h1FFC || w_pc4F !== 13'h0000 ||
            w_instrF !== pat(13'h1FFC)) begin
            failures++;
            $display("FAIL wrap_entry: got v=%b pc=%h pc4=%h i=%h want 1/1ffc/0000/%h",
                     w_validF, w_pcF, w_pc4F, w_instrF, pat(13'h1FFC));
        end
        checks++;
        if (w_req !== 1'b1 || w_addr !== 13'h0000) begin
            failures++;
            $display("FAIL wrap_next_req: got req=%b addr=%h want 1/0000", w_req, w_addr);
        end
    endtask

    initial begin
        aclr          = 1'b1;
        en            = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = '0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        w_en          = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_rvalid      = 1'b0;
        w_rdata       = '0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_aclr_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
